// File: rtl/userio_joy_poller.sv
// rtl/userio_joy_poller.sv - DB15 joystick shift-chain poller for the UserIO port
// Optional debounce: define USERIO_JOY_DEBOUNCE_EN.
module userio_joy_poller #(
  parameter int CLK_DIV  = 8,
  parameter int POLL_GAP = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic        joy_clk,
  output logic        joy_load,
  input  logic        joy_data,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        frame_done,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE, GAP} state_t;

  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);

  state_t      state, state_nx;
  logic [7:0]  div_cnt;
  logic [4:0]  bit_cnt;
  logic [15:0] gap_cnt;
  logic [31:0] sh;
  logic [1:0]  data_sync;
  logic        upd, upd_q, accept;
  logic        div_end, gap_end;

  assign div_end = (div_cnt == DIV_LAST);
  assign gap_end = (gap_cnt == GAP_LAST);

`ifdef USERIO_JOY_DEBOUNCE_EN
  logic [31:0] prev;
  assign accept = (sh == prev);
`else
  assign accept = 1'b1;
`endif

  assign upd = (state == DONE) && enable && accept;

  always_comb begin
    state_nx = state;
    if (!enable) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:     state_nx = LOAD;
        LOAD:     if (div_end) state_nx = SHIFT_LO;
        SHIFT_LO: if (div_end) state_nx = SHIFT_HI;
        SHIFT_HI: if (div_end) state_nx = (bit_cnt == 5'd31) ? DONE : SHIFT_LO;
        DONE:     state_nx = GAP;
        GAP:      if (gap_end) state_nx = LOAD;
        default:  state_nx = IDLE;
      endcase
    end
  end

  // Strobes are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      joy_clk    <= 1'b0;
      joy_load   <= 1'b1;
      joystick1  <= '0;
      joystick2  <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      sh         <= '1;
      data_sync  <= 2'b11;
      upd_q      <= 1'b0;
`ifdef USERIO_JOY_DEBOUNCE_EN
      prev       <= '1;
`endif
    end else begin
      state     <= state_nx;
      data_sync <= {data_sync[0], joy_data};
      joy_clk   <= (state_nx == SHIFT_HI);
      joy_load  <= (state_nx != LOAD);
      busy      <= (state_nx inside {LOAD, SHIFT_LO, SHIFT_HI, DONE});

      div_cnt <= (state_nx == state && state inside {LOAD, SHIFT_LO, SHIFT_HI})
                 ? div_cnt + 8'd1 : 8'd0;
      gap_cnt <= (state_nx == GAP && state == GAP) ? gap_cnt + 16'd1 : 16'd0;

      if (state == SHIFT_HI && state_nx == SHIFT_LO)
        bit_cnt <= bit_cnt + 5'd1;
      else if (state_nx != SHIFT_LO && state_nx != SHIFT_HI)
        bit_cnt <= '0;

      if (state == SHIFT_LO && div_end)
        sh[bit_cnt] <= data_sync[1];

      // Chain reads 0 for a pressed button; both words change together.
      if (upd) begin
        joystick1 <= ~sh[15:0];
        joystick2 <= ~sh[31:16];
      end
`ifdef USERIO_JOY_DEBOUNCE_EN
      if (state == DONE)
        prev <= sh;
`endif
      upd_q      <= upd;
      frame_done <= upd_q;
    end
  end

endmodule

// File: tb/tb_userio_joy_poller.sv
// tb/tb_userio_joy_poller.sv - scoreboard bench for userio_joy_poller
module tb_userio_joy_poller;

  localparam int CLK_DIV  = 8;
  localparam int POLL_GAP = 1024;
  localparam int PERIOD   = CLK_DIV * 65 + 1 + POLL_GAP;
  localparam int LAT      = CLK_DIV * 65 + 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        joy_data = 1'b1;
  logic        joy_clk, joy_load, frame_done, busy;
  logic [15:0] joystick1, joystick2;

  userio_joy_poller #(.CLK_DIV(CLK_DIV), .POLL_GAP(POLL_GAP)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .joy_clk(joy_clk), .joy_load(joy_load), .joy_data(joy_data),
    .joystick1(joystick1), .joystick2(joystick2),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int          errors = 0, checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pat = '1;
  logic [31:0] e;
  int          idx = 0, cyc = 0, rises = 0, last_fall = -1;
  int          load_len = 0, fd_len = 0, frames = 0;
  logic        prev_clk = 1'b0, prev_load = 1'b1, prev_fd = 1'b0;
  bit          period_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Chain model plus scoreboard monitor, evaluated away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (!joy_load && prev_load) begin
      if (period_en && last_fall >= 0) check("period", 32'(cyc - last_fall), 32'(PERIOD));
      last_fall = cyc;
      rises = 0;
      load_len = 0;
    end
    if (!joy_load) load_len++;
    if (joy_load && !prev_load) check("load_len", 32'(load_len), 32'(CLK_DIV));
    if (joy_clk && !prev_clk) rises++;
    if (!joy_load) idx = 0;
    else if (joy_clk && !prev_clk) idx++;
    joy_data = (idx < 32) ? pat[idx] : 1'b1;

    if (frame_done) fd_len++;
    if (frame_done && !prev_fd) begin
      frames++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got frame_done=1, expected 0 at cycle %0d", cyc);
      end else begin
        e = exp_q.pop_front();
        check("joystick1", {16'h0, joystick1}, {16'h0, e[15:0]});
        check("joystick2", {16'h0, joystick2}, {16'h0, e[31:16]});
        check("latency", 32'(cyc - last_fall), 32'(LAT));
        check("clk_rises", 32'(rises), 32'd32);
        check("busy_in_gap", {31'h0, busy}, 32'h0);
      end
    end
    if (!frame_done && prev_fd) begin
      check("fd_width", 32'(fd_len), 32'd1);
      fd_len = 0;
    end
    prev_clk  = joy_clk;
    prev_load = joy_load;
    prev_fd   = frame_done;
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int start = frames;
    int k = 0;
    while (frames < start + n && k < budget) begin tick(); k++; end
    if (frames < start + n) begin
      checks++;
      errors++;
      $display("FAIL timeout_frames: got %0d frames, expected %0d", frames - start, n);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_joy_clk"}, {31'h0, joy_clk}, 32'h0);
    check({tag, "_joy_load"}, {31'h0, joy_load}, 32'h1);
    check({tag, "_js1"}, {16'h0, joystick1}, 32'h0);
    check({tag, "_js2"}, {16'h0, joystick2}, 32'h0);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check({tag, "_frame_done"}, {31'h0, frame_done}, 32'h0);
  endtask

  task automatic reset_and_idle;
    int tog = 0;
    logic pc, pl, pb;
    reset_n = 1'b0;
    enable = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    pc = joy_clk; pl = joy_load; pb = busy;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (joy_clk != pc || joy_load != pl || busy != pb) tog++;
      pc = joy_clk; pl = joy_load; pb = busy;
    end
    check("idle_toggles", 32'(tog), 32'h0);
  endtask

`ifdef USERIO_JOY_DEBOUNCE_EN
  task automatic wait_scan;
    int k = 0;
    while (!busy && k < PERIOD) begin tick(); k++; end
    while (busy && k < 2 * PERIOD) begin tick(); k++; end
    if (busy || k >= 2 * PERIOD) begin
      checks++;
      errors++;
      $display("FAIL timeout_scan: got busy=%0d after %0d cycles, expected scan end", busy, k);
    end
  endtask

  task automatic run_tests;
    pat = 32'hFFFF_FFFE;
    enable = 1'b1;
    wait_scan();
    check("db_a_js1", {16'h0, joystick1}, 32'h0);
    check("db_a_js2", {16'h0, joystick2}, 32'h0);
    pat = 32'h7FFF_FFFF;
    wait_scan();
    check("db_b1_js1", {16'h0, joystick1}, 32'h0);
    check("db_b1_js2", {16'h0, joystick2}, 32'h0);
    exp_q.push_back({16'h8000, 16'h0000});
    wait_frames(1, PERIOD + 100);
  endtask
`else
  task automatic wait_rise_count(input int n);
    int k = 0;
    while (joy_load && k < PERIOD + 100) begin tick(); k++; end
    while (rises < n && k < PERIOD + 700) begin tick(); k++; end
    if (rises < n) begin
      checks++;
      errors++;
      $display("FAIL timeout_rises: got %0d rises, expected %0d", rises, n);
    end
  endtask

  task automatic run_tests;
    int k;
    int early_clk;
    // Bits 0 and 17 pressed.
    pat = 32'hFFFD_FFFE;
    repeat (3) exp_q.push_back({16'h0002, 16'h0001});
    period_en = 1'b1;
    enable = 1'b1;
    wait_frames(3, 3 * PERIOD + 200);
    period_en = 1'b0;

    pat = 32'hFFFF_FF00;
    exp_q.push_back({16'h0000, 16'h00FF});
    wait_frames(1, PERIOD + 100);

    // Abort on the 10th shift clock.
    wait_rise_count(10);
    enable = 1'b0;
    tick();
    check("abort_joy_clk", {31'h0, joy_clk}, 32'h0);
    check("abort_joy_load", {31'h0, joy_load}, 32'h1);
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_js1", {16'h0, joystick1}, 32'h00FF);
    repeat (700) tick();
    check("abort_hold_js1", {16'h0, joystick1}, 32'h00FF);

    enable = 1'b1;
    k = 0;
    early_clk = 0;
    while (joy_load && k < 100) begin
      if (joy_clk) early_clk++;
      tick();
      k++;
    end
    check("restart_load", {31'h0, joy_load}, 32'h0);
    check("restart_no_clk", 32'(early_clk), 32'h0);
    exp_q.push_back({16'h0000, 16'h00FF});
    wait_frames(1, PERIOD + 100);

    // Reset during SHIFT_HI of bit 20.
    wait_rise_count(21);
    reset_n = 1'b0;
    tick();
    check_reset_outputs("midreset");
    tick();
    reset_n = 1'b1;
    pat = 32'h7FFF_FFFF;
    exp_q.push_back({16'h8000, 16'h0000});
    wait_frames(1, PERIOD + 100);
  endtask
`endif

  initial begin
    reset_and_idle();
    run_tests();
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
